// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
// State encoding, bus sign mask and word size.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_REQ     = 3'd1,
        RD_WAIT_HI = 3'd2,
        RD_WAIT_LO = 3'd3,
        WR_REQ     = 3'd4,
        WR_WAIT_HI = 3'd5,
        WR_WAIT_LO = 3'd6,
        FINISH     = 3'd7
    } dma_state_e;

    localparam logic [3:0] SIGN_MASK_WORD = 4'b0111;
    localparam int         WORD_BYTES     = 4;

endpackage

// File: rtl/dma_bus_handshake.sv
// Single-request bus initiator: registers one read or write request,
// tracks the responder stall high->low and captures read data.
module dma_bus_handshake #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_go,
    input  logic              wr_go,
    input  logic [ADDR_W-1:0] go_addr,
    input  logic [31:0]       go_wdata,
    input  logic              stall,
    input  logic [31:0]       rdata_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              ack,
    output logic [31:0]       word_nxt
);

    logic        pend;
    logic        hi;
    logic        rd_op;
    logic [31:0] word;

    // Ack fires in the first stall-low cycle after the stall was seen high.
    always_comb begin
        ack      = pend && hi && !stall;
        word_nxt = (ack && rd_op) ? rdata_in : word;
    end

    // Request registers, stall tracking and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            pend           <= 1'b0;
            hi             <= 1'b0;
            rd_op          <= 1'b0;
            word           <= '0;
        end else begin
            mem_memread  <= rd_go;
            mem_memwrite <= wr_go;
            if (rd_go || wr_go) begin
                mem_addr <= go_addr;
                pend     <= 1'b1;
                hi       <= 1'b0;
                rd_op    <= rd_go;
            end else if (ack) begin
                pend <= 1'b0;
                hi   <= 1'b0;
            end else if (pend && stall) begin
                hi <= 1'b1;
            end
            if (wr_go) begin
                mem_write_data <= go_wdata;
            end
            if (ack && rd_op) begin
                word <= rdata_in;
            end
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// Word-wise block copy engine on the data-memory request/stall port.
// Optional running checksum of copied words: DMA_CHECKSUM_EN.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic [3:0]        mem_sign_mask,
    input  logic              mem_clk_stall,
    input  logic [31:0]       mem_read_data
`ifdef DMA_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    dma_state_e        state, nxt;
    logic [ADDR_W-1:0] src_q, dst_q, src_n, dst_n;
    logic [LEN_W-1:0]  rem_q, rem_n;
    logic              busy_d, done_d;
    logic              rd_go, wr_go, accept, capture;
    logic [ADDR_W-1:0] go_addr;
    logic              ack;
    logic [31:0]       word_nxt;

    // Next state, working-register updates and registered-output values.
    always_comb begin
        nxt     = state;
        src_n   = src_q;
        dst_n   = dst_q;
        rem_n   = rem_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !mem_clk_stall) begin
                    accept = 1'b1;
                    src_n  = {src_addr[ADDR_W-1:2], 2'b00};
                    dst_n  = {dst_addr[ADDR_W-1:2], 2'b00};
                    rem_n  = len_words;
                    nxt    = (len_words == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ:     nxt = RD_WAIT_HI;
            RD_WAIT_HI: if (mem_clk_stall) nxt = RD_WAIT_LO;
            RD_WAIT_LO: begin
                if (ack) begin
                    capture = 1'b1;
                    nxt     = WR_REQ;
                end
            end
            WR_REQ:     nxt = WR_WAIT_HI;
            WR_WAIT_HI: if (mem_clk_stall) nxt = WR_WAIT_LO;
            WR_WAIT_LO: begin
                if (ack) begin
                    src_n = src_q + ADDR_W'(WORD_BYTES);
                    dst_n = dst_q + ADDR_W'(WORD_BYTES);
                    rem_n = rem_q - LEN_W'(1);
                    if (rem_n == '0) begin
                        nxt    = FINISH;
                        done_d = 1'b1;
                    end else begin
                        nxt = RD_REQ;
                    end
                end
            end
            // A zero-length copy arrives here without a pulse yet.
            FINISH: begin
                nxt    = IDLE;
                done_d = !done;
            end
            default: nxt = IDLE;
        endcase
        rd_go   = (nxt == RD_REQ);
        wr_go   = (nxt == WR_REQ);
        go_addr = rd_go ? src_n : dst_n;
        busy_d  = (nxt != IDLE) && (nxt != FINISH);
    end

    // State, working registers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_sign_mask <= SIGN_MASK_WORD;
        end else begin
            state         <= nxt;
            src_q         <= src_n;
            dst_q         <= dst_n;
            rem_q         <= rem_n;
            busy          <= busy_d;
            done          <= done_d;
            mem_sign_mask <= SIGN_MASK_WORD;
        end
    end

`ifdef DMA_CHECKSUM_EN
    // Running sum of every word read, restarted on each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (capture) begin
            checksum <= checksum + word_nxt;
        end
    end
`endif

    dma_bus_handshake #(
        .ADDR_W (ADDR_W)
    ) u_hs (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_go          (rd_go),
        .wr_go          (wr_go),
        .go_addr        (go_addr),
        .go_wdata       (word_nxt),
        .stall          (mem_clk_stall),
        .rdata_in       (mem_read_data),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .ack            (ack),
        .word_nxt       (word_nxt)
    );

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a stalling responder model
// and a queue scoreboard of expected bus requests.
module tb_dma_copy_engine;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [9:0]  len_words = '0;
    logic        busy, done;
    logic [11:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic        mem_clk_stall = 1'b0;
    logic [31:0] mem_read_data = '0;
`ifdef DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    op_t         sbq[$];
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          cnt = 0;

    dma_copy_engine #(
        .ADDR_W (12),
        .LEN_W  (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len_words      (len_words),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_clk_stall  (mem_clk_stall),
        .mem_read_data  (mem_read_data)
`ifdef DMA_CHECKSUM_EN
        ,.checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Responder: stall for two cycles after each request; scoreboard pop.
    always @(posedge clk) begin
        op_t e;
        #1;
        if (cnt > 0) begin
            mem_clk_stall = 1'b1;
            cnt--;
        end else begin
            mem_clk_stall = 1'b0;
        end
        if (mem_memread || mem_memwrite) begin
            chk("proto", {30'd0, mem_memread && mem_memwrite, mem_clk_stall}, 0);
            chk("sb_nonempty", {31'd0, sbq.size() != 0}, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("op_kind", {31'd0, mem_memwrite}, {31'd0, e.wr});
                chk("op_addr", {20'd0, mem_addr}, {20'd0, e.addr});
                if (mem_memwrite) begin
                    chk("wr_data", mem_write_data, e.data);
                    mem[mem_addr[11:2]] = mem_write_data;
                end else begin
                    chk("rd_data", mem[mem_addr[11:2]], e.data);
                    mem_read_data = mem[mem_addr[11:2]];
                end
            end
            cnt = 2;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_rd"}, {31'd0, mem_memread}, 0);
        chk({tag, "_wr"}, {31'd0, mem_memwrite}, 0);
        chk({tag, "_addr"}, {20'd0, mem_addr}, 0);
        chk({tag, "_wdata"}, mem_write_data, 0);
        chk({tag, "_mask"}, {28'd0, mem_sign_mask}, 32'h7);
    endtask

    task automatic run_copy(input logic [11:0] s, input logic [11:0] d,
                            input int n, input int restart_k);
        logic [11:0] sa, da;
        logic [31:0] w;
        int exp_done, done_at, ndone, busy_bad;
        for (int i = 0; i < n; i++) begin
            sa = {s[11:2], 2'b00} + 12'(4 * i);
            da = {d[11:2], 2'b00} + 12'(4 * i);
            w  = ref_mem[sa[11:2]];
            sbq.push_back('{1'b0, sa, w});
            sbq.push_back('{1'b1, da, w});
            ref_mem[da[11:2]] = w;
        end
        exp_done = (n == 0) ? 1 : 8 * n;
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = 10'(n);
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_at  = -1;
        ndone    = 0;
        busy_bad = 0;
        for (int k = 0; k < exp_done + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (k < 8 * n)) busy_bad++;
            if (k == restart_k) begin
                src_addr  = 12'h300;
                dst_addr  = 12'h340;
                len_words = 10'd7;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_cycle", done_at, exp_done);
        chk("done_pulses", ndone, 1);
        chk("busy_window", busy_bad, 0);
        chk("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 32'h1111_1111 * (i + 1);
            ref_mem[i] = 32'h1111_1111 * (i + 1);
        end
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Four-word copy.
        run_copy(12'h000, 12'h100, 4, -1);
        // Zero length: no bus traffic, done in cycle 1.
        run_copy(12'h010, 12'h020, 0, -1);
        // Source wraps past the top; unaligned destination.
        run_copy(12'hFF8, 12'h203, 3, -1);
        // Second start inside a running copy is ignored.
        run_copy(12'h020, 12'h400, 2, 5);

        // Reset while the responder is still stalling on a read.
        sbq.push_back('{1'b0, 12'h040, ref_mem[16]});
        @(negedge clk);
        src_addr  = 12'h040;
        dst_addr  = 12'h500;
        len_words = 10'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        #1 rst_n = 1'b1;
        src_addr  = 12'h080;
        len_words = 10'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("drop_busy", {31'd0, busy}, 0);
        chk("drop_rd", {31'd0, mem_memread}, 0);
        @(negedge clk);
        chk("drop_busy2", {31'd0, busy}, 0);
        run_copy(12'h080, 12'h600, 2, -1);

`ifdef DMA_CHECKSUM_EN
        mem[448] = 32'd1;  ref_mem[448] = 32'd1;
        mem[449] = 32'd2;  ref_mem[449] = 32'd2;
        mem[450] = 32'd3;  ref_mem[450] = 32'd3;
        mem[451] = 32'hFFFF_FFFF;
        ref_mem[451] = 32'hFFFF_FFFF;
        run_copy(12'h700, 12'h780, 4, -1);
        chk("checksum", checksum, 32'h0000_0005);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
